// File: rtl/mont_digit_red.sv
// rtl/mont_digit_red.sv - word-serial Montgomery reduction, 48-bit digits, NDIG iterations.
// Optional macro FINAL_SUB_EN adds a final conditional subtraction of MOD (one extra cycle).
module mont_digit_red #(
    parameter logic [255:0] MOD    = 256'd1,
    parameter logic [47:0]  MINV   = 48'hFFFF_FFFF_FFFF,
    parameter int           XM_LAT = 1,
    parameter int           NDIG   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] t_in,
    output logic [47:0]  q_out,
    input  logic [255:0] r_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [256:0] res,
    output logic         busy,
    output logic         digit_err
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int WW = $clog2(XM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q,
        S_WAIT,
        S_ACC,
        S_SUB,
        S_DONE
    } state_t;

    state_t          state;
    logic [512:0]    acc;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wcnt;

    logic [47:0]     q_next;
    logic [513:0]    sum;
    logic [512:0]    acc_next;

    // Only the low half of the 48x48 product is needed for q.
    assign q_next   = 48'(acc[47:0] * MINV);
    assign sum      = {1'b0, acc} + {258'd0, r_in};
    assign acc_next = 513'(sum >> 48);

`ifdef FINAL_SUB_EN
    logic [256:0] acc_lo;
    logic [256:0] acc_sub;
    assign acc_lo  = acc[256:0];
    assign acc_sub = acc_lo - {1'b0, MOD};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            q_out     <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc      <= {1'b0, t_in};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_Q;
                    end
                end
                S_Q: begin
                    q_out <= q_next;
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt == WW'(XM_LAT - 1)) begin
                        state <= S_ACC;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_ACC: begin
                    acc <= acc_next;
                    // A non-zero low digit means r_in did not match the q we issued.
                    if (sum[47:0] != 48'd0) begin
                        digit_err <= 1'b1;
                    end
                    if (cnt == CW'(NDIG - 1)) begin
                        busy <= 1'b0;
`ifdef FINAL_SUB_EN
                        state <= S_SUB;
`else
                        res       <= acc_next[256:0];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`endif
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_Q;
                    end
                end
`ifdef FINAL_SUB_EN
                S_SUB: begin
                    res       <= (acc_lo >= {1'b0, MOD}) ? acc_sub : acc_lo;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_digit_red.sv
// tb/tb_mont_digit_red.sv - randomized bench for mont_digit_red against a modular-arithmetic reference.
module tb_mont_digit_red;

    // The product port is 256 bits wide, so the test modulus stays below 2^208 to keep q*M in range.
    localparam logic [255:0] MOD_TB = (256'd1 << 207) - 256'd19;
    localparam int           XM_LAT = 1;
    localparam int           NDIG   = 6;
`ifdef FINAL_SUB_EN
    localparam int           LAT_EXP = NDIG * (XM_LAT + 2) + 1;
`else
    localparam int           LAT_EXP = NDIG * (XM_LAT + 2);
`endif

    function automatic logic [47:0] calc_minv(input logic [47:0] m);
        logic [47:0] x;
        x = m;
        for (int i = 0; i < 6; i++) begin
            x = x * (48'd2 - m * x);
        end
        return ~x + 48'd1;
    endfunction

    localparam logic [47:0] MINV_TB = calc_minv(MOD_TB[47:0]);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] t_in;
    logic [47:0]  q_out;
    logic [255:0] r_in;
    logic         out_valid;
    logic         out_ready;
    logic [256:0] res;
    logic         busy;
    logic         digit_err;

    logic         corrupt;
    logic         q_seen_nz;
    logic [255:0] r_pipe [XM_LAT];

    int           n_checks = 0;
    int           n_errors = 0;
    logic [511:0] m512;
    logic [511:0] rinv;

    always #5 clk = ~clk;

    mont_digit_red #(
        .MOD   (MOD_TB),
        .MINV  (MINV_TB),
        .XM_LAT(XM_LAT),
        .NDIG  (NDIG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .t_in     (t_in),
        .q_out    (q_out),
        .r_in     (r_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .busy     (busy),
        .digit_err(digit_err)
    );

    // Multiplier stage stand-in: q_out*MOD delivered XM_LAT cycles later.
    always @(posedge clk) begin
        r_pipe[0] <= 256'(q_out) * MOD_TB;
        for (int i = 1; i < XM_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
        if (q_out != 48'd0) q_seen_nz <= 1'b1;
    end
    assign r_in = r_pipe[XM_LAT-1] ^ {255'd0, corrupt};

    task automatic check_val(input string tag, input logic [519:0] got, input logic [519:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mont_ref(input logic [511:0] t);
        return ((t % m512) * rinv) % m512;
    endfunction

    task automatic check_res(input string tag, input logic [256:0] got, input logic [511:0] t);
        logic [511:0] g;
        g = {255'd0, got};
`ifdef FINAL_SUB_EN
        check_val(tag, g, mont_ref(t));
`else
        check_val(tag, (g < 2 * m512) ? (g % m512) : '1, mont_ref(t));
`endif
    endtask

    task automatic run_op(input logic [511:0] t, input int stall, input bit noise,
                          output logic [256:0] r, output int lat);
        int w;
        bit stable;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        t_in     = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (noise) begin
                in_valid = 1'($urandom);
                t_in     = {16{$urandom}};
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check_val("out_valid", out_valid, 1);
        r = res;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (res !== r || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) check_val("stall_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("hs_valid_ready", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [256:0] r;
        logic [511:0] t;
        logic [511:0] tmax;
        int           lat;

        m512 = {256'd0, MOD_TB};
        rinv = 512'd1;
        repeat (288) begin
            if (rinv[0]) rinv = rinv + m512;
            rinv = rinv >> 1;
        end
        tmax = m512 << 288;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; t_in = '0; corrupt = 1'b0; q_seen_nz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outs", {in_ready, out_valid, busy, digit_err}, 4'b1000);
        check_val("rst_q", q_out, 0);
        check_val("rst_res", res, 0);
        rst = 1'b0;

        run_op(512'd0, 0, 1'b0, r, lat);
        check_val("zero_lat", lat, LAT_EXP);
        check_val("zero_res", r, 0);
        check_val("zero_q", q_seen_nz, 0);
        check_val("zero_err", digit_err, 0);

        run_op(512'd1 << 288, 0, 1'b0, r, lat);
        check_val("r288_res", r, 1);
        check_val("r288_q", q_seen_nz, 0);

        run_op({256'd0, MOD_TB}, 0, 1'b0, r, lat);
        check_val("mod_lat", lat, LAT_EXP);
`ifdef FINAL_SUB_EN
        check_val("mod_res", r, 0);
`else
        check_val("mod_res", r, {1'b0, MOD_TB});
`endif
        check_val("mod_err", digit_err, 0);

        // Reset during the ACC cycle of digit 3 discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        t_in = {16{$urandom}};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_val("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("mid_rst_outs", {in_ready, out_valid, busy}, 3'b100);
        check_val("mid_rst_q", q_out, 0);
        run_op(512'd1 << 288, 0, 1'b0, r, lat);
        check_val("after_rst_res", r, 1);

        for (int v = 0; v < 1000; v++) begin
            t = {16{$urandom}};
            for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
            t = t % tmax;
            run_op(t, 5, 1'b1, r, lat);
            check_val("rand_lat", lat, LAT_EXP);
            check_res("rand_res", r, t);
        end
        check_val("rand_err", digit_err, 0);

        // Flip r_in bit 0 during the ACC cycle of digit 2.
        @(negedge clk);
        in_valid = 1'b1;
        t_in = {16{$urandom}} % tmax;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        corrupt = 1'b1;
        check_val("err_before", digit_err, 0);
        @(posedge clk);
        #1;
        corrupt = 1'b0;
        check_val("err_set", digit_err, 1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("err_op_done", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run_op(512'd0, 0, 1'b0, r, lat);
        check_val("err_sticky", digit_err, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("err_cleared", digit_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
